pe_array_ctrl: RTL
==================

Name: pe_array_ctrl

Overview:
- Sequencer for the 6x7 PE array. Takes one layer job (mode, stage, round count, active-PE mask).
- Issues the change_mode / op_stage / conv_continue controls the array consumes and watches the per-PE conv_done flags.
- Signals completion after the final round once downstream psum/output buffers report idle.
- Sits between the top-level layer scheduler and the PE array, beside the diagonal-bus ifmap NoC and the weight buffer.

Parameters:
- ROUND_W, 8, width of round counter / cfg_rounds
- DONE_BLANK, 2, cycles after a change_mode or conv_continue pulse during which pe_conv_done is ignored
- WDOG_W, 16, watchdog counter width (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  job start pulse; accepted only in IDLE
- cfg_mode  in  OP_MODE  operating mode for the job
- cfg_stage  in  OP_STAGE  op stage for the job
- cfg_rounds  in  ROUND_W  number of convolution rounds; 0 is treated as 1
- cfg_pe_mask  in  [5:0][6:0]  PEs that must report done
- pe_conv_done  in  [5:0][6:0]  per-PE conv_done from the array
- drain_idle  in  1  psum and output buffers empty, no packets in flight
- mode_out  out  OP_MODE  mode_in to the array
- change_mode  out  1  one-cycle pulse to the array
- op_stage_out  out  OP_STAGE  op_stage_in to the array
- conv_continue  out  1  one-cycle pulse to the array
- busy  out  1  job in progress
- job_done  out  1  one-cycle pulse at job end
- round_cnt  out  ROUND_W  rounds completed in the current job
- error  out  1  sticky error; cleared only by reset or the next accepted start

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - mode_out=MODE1, matching the array's reset mode; op_stage_out=0.
  - change_mode=0, conv_continue=0, busy=0, job_done=0, round_cnt=0, error=0.
  - Reset mid-job aborts the job; no completion pulse is generated.
- Configuration latching:
  - On start in IDLE, all cfg_* inputs are captured into registers.
  - cfg changes after acceptance have no effect.
  - start outside IDLE is ignored.
- States:
  - IDLE: busy=0. On start go to CFG. If the latched mask is all zero, set error and go to FIN instead.
  - CFG:
    - One cycle: change_mode=1, mode_out=latched mode, op_stage_out=latched stage. mode_out and op_stage_out hold these values until the next job.
    - Load blank counter = DONE_BLANK. Go to RUN.
  - RUN:
    - While blank counter > 0, decrement it and ignore done flags.
    - Once the counter is 0, advance when (pe_conv_done & mask) == mask. Unmasked PE flags are don't-care.
    - On advance, round_cnt increments.
    - If round_cnt+1 < rounds, go to CONT; otherwise go to DRAIN.
  - CONT: one cycle with conv_continue=1. Reload blank counter = DONE_BLANK. Go to RUN.
  - DRAIN: wait for drain_idle=1 for 2 consecutive cycles, then go to FIN.
  - FIN: job_done=1 for one cycle, busy=0. Go to IDLE.
- busy is 1 in CFG, RUN, CONT and DRAIN.
- Timing:
  - change_mode and conv_continue are registered, and never both high in the same cycle.
  - Minimum latency from start to job_done with 1 round, done already high and drain idle: 1 (CFG) + DONE_BLANK + 1 (RUN eval) + 2 (DRAIN) + 1 (FIN) = DONE_BLANK + 5 cycles.
- Boundary conditions:
  - Done flags already high from a previous job are masked by the blanking window; DONE_BLANK must cover the PE clear latency.
  - round_cnt saturates at 2^ROUND_W-1 and does not wrap.
  - A start in the same cycle as FIN is ignored.
  - start and rst_n low together: reset wins.

Optional Feature:
- Macro: PE_ARRAY_CTRL_WDOG_EN.
- When defined:
  - A WDOG_W-bit counter clears on every state change and increments in RUN and DRAIN.
  - At all-ones it sets error, forces FIN, and emits job_done.
- When undefined: no watchdog; the controller waits indefinitely, and error is raised only for an empty mask.

Decomposition:
- OP_MODE and OP_STAGE come from the existing shared package.
- Add to the shared package:
  - CTRL_STATE enum {IDLE, CFG, RUN, CONT, DRAIN, FIN}.
  - A PE_ROWS=6 / PE_COLS=7 localparam pair.
- Natural sub-module: pe_done_reduce, a combinational masked AND-reduction over [5:0][6:0] with a registered all-done output.
  - This adds one cycle, already counted in "RUN eval".

Test Plan:
- MODE2, rounds=3, full mask; raise all done 10 cycles after each pulse, drain_idle=1 -> exactly one change_mode, two conv_continue pulses, round_cnt=3, one job_done.
- Mask = only row 0; rows 1-5 done stay 0; row0 done=1 -> job completes; unmasked flags do not block it.
- Done flags held high from the previous job with DONE_BLANK=2 -> no advance within the first 2 RUN cycles; drop done then re-raise -> single advance.
- cfg_rounds=0 -> behaves as 1 round: no conv_continue, one job_done.
- drain_idle toggles 1,0,1,1 -> job_done only after the second consecutive 1.
- rst_n low mid-RUN -> next cycle all outputs at reset values, mode_out=MODE1; start during busy ignored; empty mask -> error=1 plus job_done.

Source files
------------

// File: rtl/pe_array_ctrl_pkg.sv
// Shared types for the PE array sequencer: array operating mode/stage,
// controller states and the PE array geometry.
package pe_array_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE1 = 2'd0,
        MODE2 = 2'd1,
        MODE3 = 2'd2,
        MODE4 = 2'd3
    } op_mode_e;

    typedef enum logic [1:0] {
        STAGE0 = 2'd0,
        STAGE1 = 2'd1,
        STAGE2 = 2'd2,
        STAGE3 = 2'd3
    } op_stage_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CFG   = 3'd1,
        RUN   = 3'd2,
        CONT  = 3'd3,
        DRAIN = 3'd4,
        FIN   = 3'd5
    } ctrl_state_e;

    localparam int PE_ROWS = 6;
    localparam int PE_COLS = 7;

endpackage

// File: rtl/pe_array_ctrl_done_reduce.sv
// pe_done_reduce: masked AND-reduction of the per-PE conv_done flags.
// The all-done result is registered, so it lags the flags by one cycle.
module pe_done_reduce
    import pe_array_ctrl_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [PE_ROWS-1:0][PE_COLS-1:0]  mask,
    input  logic [PE_ROWS-1:0][PE_COLS-1:0]  done,
    output logic                             all_done
);

    logic all_done_d, all_done_q;

    // Every masked PE must report done; unmasked flags are ignored.
    always_comb all_done_d = ((done & mask) == mask);

    // Register the reduction to keep the 42-input tree off the FSM path.
    always_ff @(posedge clk) begin
        if (!rst_n) all_done_q <= 1'b0;
        else        all_done_q <= all_done_d;
    end

    assign all_done = all_done_q;

endmodule

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: sequences one layer job on the 6x7 PE array.
// Latches the job, pulses change_mode, then loops RUN/CONT per round,
// drains and pulses job_done.
// Optional watchdog: define PE_ARRAY_CTRL_WDOG_EN.
module pe_array_ctrl
    import pe_array_ctrl_pkg::*;
#(
    parameter int ROUND_W    = 8,
    parameter int DONE_BLANK = 2,
    parameter int WDOG_W     = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  op_mode_e                         cfg_mode,
    input  op_stage_e                        cfg_stage,
    input  logic [ROUND_W-1:0]               cfg_rounds,
    input  logic [PE_ROWS-1:0][PE_COLS-1:0]  cfg_pe_mask,
    input  logic [PE_ROWS-1:0][PE_COLS-1:0]  pe_conv_done,
    input  logic                             drain_idle,
    output op_mode_e                         mode_out,
    output logic                             change_mode,
    output op_stage_e                        op_stage_out,
    output logic                             conv_continue,
    output logic                             busy,
    output logic                             job_done,
    output logic [ROUND_W-1:0]               round_cnt,
    output logic                             error
);

    localparam int BLANK_W = $clog2(DONE_BLANK + 2);

    ctrl_state_e                      state_q, state_d;
    logic [BLANK_W-1:0]               blank_q, blank_d;
    logic [ROUND_W-1:0]               rounds_q, rounds_d;
    logic [PE_ROWS-1:0][PE_COLS-1:0]  mask_q, mask_d;
    logic [ROUND_W-1:0]               round_cnt_q, round_cnt_d;
    logic                             drain_seen_q, drain_seen_d;
    logic                             error_q, error_d;
    op_mode_e                         mode_q, mode_d;
    op_stage_e                        stage_q, stage_d;
    logic                             change_mode_q, change_mode_d;
    logic                             conv_continue_q, conv_continue_d;
    logic                             job_done_q, job_done_d;
    logic                             busy_q, busy_d;
    logic [ROUND_W:0]                 next_rnd;
    logic                             all_done;
`ifdef PE_ARRAY_CTRL_WDOG_EN
    logic [WDOG_W-1:0]                wdog_q, wdog_d;
`endif

    pe_done_reduce u_done_reduce (
        .clk      (clk),
        .rst_n    (rst_n),
        .mask     (mask_q),
        .done     (pe_conv_done),
        .all_done (all_done)
    );

    // Next-state, job latching and registered-output decode.
    always_comb begin
        state_d      = state_q;
        blank_d      = blank_q;
        rounds_d     = rounds_q;
        mask_d       = mask_q;
        round_cnt_d  = round_cnt_q;
        drain_seen_d = drain_seen_q;
        error_d      = error_q;
        mode_d       = mode_q;
        stage_d      = stage_q;
        next_rnd     = (ROUND_W+1)'(round_cnt_q) + (ROUND_W+1)'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    rounds_d    = (cfg_rounds == '0) ? ROUND_W'(1) : cfg_rounds;
                    mask_d      = cfg_pe_mask;
                    round_cnt_d = '0;
                    error_d     = 1'b0;
                    if (cfg_pe_mask == '0) begin
                        // Nothing could ever report done: fail the job at once.
                        error_d = 1'b1;
                        state_d = FIN;
                    end else begin
                        mode_d  = cfg_mode;
                        stage_d = cfg_stage;
                        state_d = CFG;
                    end
                end
            end
            CFG, CONT: begin
                // Stale done flags are ignored while the PEs clear them.
                blank_d = BLANK_W'(DONE_BLANK);
                state_d = RUN;
            end
            RUN: begin
                if (blank_q != '0) begin
                    blank_d = blank_q - BLANK_W'(1);
                end else if (all_done) begin
                    if (round_cnt_q != '1) round_cnt_d = next_rnd[ROUND_W-1:0];
                    if (next_rnd < (ROUND_W+1)'(rounds_q)) begin
                        state_d = CONT;
                    end else begin
                        drain_seen_d = 1'b0;
                        state_d      = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Two consecutive idle cycles filter a momentary gap between packets.
                if (drain_idle) begin
                    if (drain_seen_q) state_d = FIN;
                    else              drain_seen_d = 1'b1;
                end else begin
                    drain_seen_d = 1'b0;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef PE_ARRAY_CTRL_WDOG_EN
        if ((state_q == RUN || state_q == DRAIN) && wdog_q == '1) begin
            error_d = 1'b1;
            state_d = FIN;
        end
        if (state_d != state_q)                        wdog_d = '0;
        else if (state_q == RUN || state_q == DRAIN)   wdog_d = wdog_q + WDOG_W'(1);
        else                                           wdog_d = wdog_q;
`endif

        change_mode_d   = (state_d == CFG);
        conv_continue_d = (state_d == CONT);
        job_done_d      = (state_d == FIN);
        busy_d          = (state_d == CFG) || (state_d == RUN) ||
                          (state_d == CONT) || (state_d == DRAIN);
    end

    // State and registered outputs; reset aborts any job silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            blank_q         <= '0;
            rounds_q        <= '0;
            mask_q          <= '0;
            round_cnt_q     <= '0;
            drain_seen_q    <= 1'b0;
            error_q         <= 1'b0;
            mode_q          <= MODE1;
            stage_q         <= STAGE0;
            change_mode_q   <= 1'b0;
            conv_continue_q <= 1'b0;
            job_done_q      <= 1'b0;
            busy_q          <= 1'b0;
`ifdef PE_ARRAY_CTRL_WDOG_EN
            wdog_q          <= '0;
`endif
        end else begin
            state_q         <= state_d;
            blank_q         <= blank_d;
            rounds_q        <= rounds_d;
            mask_q          <= mask_d;
            round_cnt_q     <= round_cnt_d;
            drain_seen_q    <= drain_seen_d;
            error_q         <= error_d;
            mode_q          <= mode_d;
            stage_q         <= stage_d;
            change_mode_q   <= change_mode_d;
            conv_continue_q <= conv_continue_d;
            job_done_q      <= job_done_d;
            busy_q          <= busy_d;
`ifdef PE_ARRAY_CTRL_WDOG_EN
            wdog_q          <= wdog_d;
`endif
        end
    end

    assign mode_out      = mode_q;
    assign op_stage_out  = stage_q;
    assign change_mode   = change_mode_q;
    assign conv_continue = conv_continue_q;
    assign busy          = busy_q;
    assign job_done      = job_done_q;
    assign round_cnt     = round_cnt_q;
    assign error         = error_q;

endmodule
